// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package serial_sub_pkg;

  // Controller states: wait for a request, shift one bit per cycle, present the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Legal operand widths.
  localparam int unsigned WidthMin = 1;
  localparam int unsigned WidthMax = 64;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle between a requesting datapath and the serial subtractor.
interface serial_sub_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  // Requester side.
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  // Subtractor side.
  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/fullsub.sv
// Combinational 1-bit full subtractor: in1 - in2 - bin.
module fullsub (
  input  logic in1,
  input  logic in2,
  input  logic bin,
  output logic diff,
  output logic bow
);

  assign diff = in1 ^ in2 ^ bin;
  assign bow  = (~in1 & in2) | (~(in1 ^ in2) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction controller: A - B - bin over WIDTH cycles, LSB first,
// through a single shared full-subtractor cell.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_sub_ctrl_if.slave  bus
);

  localparam int unsigned          CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0]      CntLast = CntW'(WIDTH - 1);

  if (WIDTH < WidthMin || WIDTH > WidthMax) begin : gen_width_check
    $error("serial_sub_ctrl: WIDTH out of range");
  end

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_d;
  logic             br_q;
  logic             bout_q;
  logic [CntW-1:0]  cnt_q;

  logic cell_d;
  logic cell_bo;
  logic accept;
  logic last;

  assign accept = (state_q == IDLE) && bus.start;
  assign last   = (state_q == RUN) && (cnt_q == CntLast);

  fullsub u_cell (
    .in1  (sa_q[0]),
    .in2  (sb_q[0]),
    .bin  (br_q),
    .diff (cell_d),
    .bow  (cell_bo)
  );

  // Result shift: new bit enters at the MSB; written this way so WIDTH=1 needs no slice.
  always_comb begin
    diff_d            = diff_q >> 1;
    diff_d[WIDTH-1]   = cell_d;
  end

  // Sequencing FSM; rst beats start on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (bus.start) state_q <= RUN;
        RUN:     if (cnt_q == CntLast) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand/borrow/result shift registers and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q   <= '0;
      sb_q   <= '0;
      diff_q <= '0;
      br_q   <= 1'b0;
      bout_q <= 1'b0;
      cnt_q  <= '0;
    end else if (accept) begin
      sa_q   <= bus.a;
      sb_q   <= bus.b;
      br_q   <= bus.bin;
      diff_q <= '0;
      cnt_q  <= '0;
    end else if (state_q == RUN) begin
      sa_q   <= sa_q >> 1;
      sb_q   <= sb_q >> 1;
      br_q   <= cell_bo;
      diff_q <= diff_d;
      // Counter parks on the last index so it can never wrap.
      if (last) begin
        bout_q <= cell_bo;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl at WIDTH=8 and WIDTH=1.
// Inputs change and outputs are sampled on the falling edge; j counts falling-edge
// samples after the accept edge (j=0 is the cycle right after acceptance).
module tb_serial_sub_ctrl;
  import serial_sub_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_sub_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Follow a WIDTH=8 operation from sample j0 until busy drops (bounded).
  task automatic watch8(input int j0, output int done_at, output int busy_n,
                        output int done_cnt, output logic [7:0] d, output logic bo);
    done_at  = -1;
    busy_n   = j0;
    done_cnt = 0;
    d        = '0;
    bo       = 1'b0;
    for (int j = j0; j < j0 + 24; j++) begin
      if (!bus8.busy) break;
      busy_n++;
      if (bus8.done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = j;
          d       = bus8.diff;
          bo      = bus8.bout;
        end
      end
      @(negedge clk);
    end
  endtask

  // Full WIDTH=8 operation: done at j=8, busy for 9 samples (edges k..k+9).
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input logic [7:0] ed, input logic eb, input string tag);
    int done_at, busy_n, done_cnt;
    logic [7:0] d;
    logic bo;
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.bin   = bi;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a     = ~a;
    bus8.b     = ~b;
    bus8.bin   = ~bi;
    watch8(0, done_at, busy_n, done_cnt, d, bo);
    check({tag, " done_lat"}, 64'(done_at), 64'd8);
    check({tag, " busy_len"}, 64'(busy_n), 64'd9);
    check({tag, " done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, " diff"}, 64'(d), 64'(ed));
    check({tag, " bout"}, 64'(bo), 64'(eb));
    check({tag, " diff_hold"}, 64'(bus8.diff), 64'(ed));
  endtask

  // Full WIDTH=1 operation: done at j=1, busy for 2 samples.
  task automatic op1(input logic a, input logic b, input logic bi,
                     input logic ed, input logic eb, input string tag);
    int done_at, busy_n;
    logic d, bo;
    done_at = -1;
    busy_n  = 0;
    d       = 1'b0;
    bo      = 1'b0;
    bus1.start = 1'b1;
    bus1.a     = a;
    bus1.b     = b;
    bus1.bin   = bi;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (!bus1.busy) break;
      busy_n++;
      if (bus1.done && done_at < 0) begin
        done_at = j;
        d       = bus1.diff;
        bo      = bus1.bout;
      end
      @(negedge clk);
    end
    check({tag, " done_lat"}, 64'(done_at), 64'd1);
    check({tag, " busy_len"}, 64'(busy_n), 64'd2);
    check({tag, " diff"}, 64'(d), 64'(ed));
    check({tag, " bout"}, 64'(bo), 64'(eb));
  endtask

  initial begin
    int done_at, busy_n, done_cnt;
    logic [7:0] d;
    logic bo;
    logic [63:0] acc_m, done_m, exp_acc, exp_done;
    logic prev_busy;

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0;

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    check("rst state8", 64'(dut8.state_q), 64'(IDLE));
    check("rst busy8", 64'(bus8.busy), 64'd0);
    check("rst done8", 64'(bus8.done), 64'd0);
    check("rst diff8", 64'(bus8.diff), 64'd0);
    check("rst bout8", 64'(bus8.bout), 64'd0);
    check("rst state1", 64'(dut1.state_q), 64'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Basic operations.
    op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "5A-3C");
    op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "00-01");

    // Reset three cycles after accept, with bout=1 left from the previous result.
    bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.bin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst state", 64'(dut8.state_q), 64'(IDLE));
    check("midrst busy", 64'(bus8.busy), 64'd0);
    check("midrst diff", 64'(bus8.diff), 64'd0);
    check("midrst bout", 64'(bus8.bout), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.done) done_cnt++;
      @(negedge clk);
    end
    check("midrst no_done", 64'(done_cnt), 64'd0);

    // rst and start together: rst wins.
    rst = 1'b1; bus8.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus8.start = 1'b0;
    check("rst_prio busy", 64'(bus8.busy), 64'd0);
    @(negedge clk);

    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "80-01");
    op8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, "10-0F-1");

    // Start pulsed during RUN with different operands is ignored.
    bus8.start = 1'b1; bus8.a = 8'h33; bus8.b = 8'h11; bus8.bin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h00;
    @(negedge clk);
    bus8.start = 1'b0;
    watch8(3, done_at, busy_n, done_cnt, d, bo);
    check("ign done_lat", 64'(done_at), 64'd8);
    check("ign done_cnt", 64'(done_cnt), 64'd1);
    check("ign diff", 64'(d), 64'h22);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus8.done || bus8.busy) done_cnt++;
      @(negedge clk);
    end
    check("ign no_second", 64'(done_cnt), 64'd0);

    // Start held high for 40 edges: accepts at 0,10,20,30; done pulses end at 9,19,29,39.
    acc_m = '0; done_m = '0; exp_acc = '0; exp_done = '0;
    for (int k = 0; k < 4; k++) begin
      exp_acc[10*k]    = 1'b1;
      exp_done[10*k+9] = 1'b1;
    end
    bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.bin = 1'b0;
    prev_busy = bus8.busy;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      if (bus8.busy && !prev_busy) acc_m[e] = 1'b1;
      if (bus8.done) done_m[e+1] = 1'b1;
      prev_busy = bus8.busy;
    end
    bus8.start = 1'b0;
    check("held accepts", acc_m, exp_acc);
    check("held dones", done_m, exp_done);
    check("held diff", 64'(bus8.diff), 64'h1E);
    check("held idle", 64'(bus8.busy), 64'd0);
    @(negedge clk);

    // WIDTH=1.
    op1(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "w1 0-1-1");
    op1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "w1 1-0-0");
    op1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "w1 1-1-1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
